// File: rtl/detect_faces_mul_arbiter.sv
// Round-robin arbiter sharing one unsigned x signed multiplier among NUM_REQ
// valid/ready requesters; products land in a single registered result slot.
module detect_faces_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 11,
  parameter int P_WIDTH  = 27,
  parameter int ID_WIDTH = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [P_WIDTH-1:0]   res_p,
  output logic [ID_WIDTH-1:0]         res_id,
  output logic [31:0]                 issued_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num_req
    $error("detect_faces_mul_arbiter: NUM_REQ must be in 2..8");
  end
  if (P_WIDTH != A_WIDTH + B_WIDTH) begin : g_chk_p_width
    $error("detect_faces_mul_arbiter: P_WIDTH must equal A_WIDTH+B_WIDTH");
  end
  if ((1 << ID_WIDTH) < NUM_REQ) begin : g_chk_id_width
    $error("detect_faces_mul_arbiter: ID_WIDTH too narrow for NUM_REQ");
  end

  logic                       r_res_valid;
  logic signed [P_WIDTH-1:0]  r_res_p;
  logic [ID_WIDTH-1:0]        r_res_id;
  logic [ID_WIDTH-1:0]        r_last_grant;
  logic [31:0]                r_issued_count;

  logic                       w_found;
  logic [ID_WIDTH-1:0]        w_grant;
  logic                       w_free;
  logic                       w_xfer;
  logic [A_WIDTH-1:0]         w_a;
  logic signed [B_WIDTH-1:0]  w_b;
  logic signed [P_WIDTH-1:0]  w_a_ext;
  logic signed [P_WIDTH-1:0]  w_b_ext;
  logic signed [P_WIDTH-1:0]  w_p;

  // Search starts one past the last winner and wraps at NUM_REQ (not 2^ID_WIDTH).
  always_comb begin : p_grant
    logic [ID_WIDTH-1:0] idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = r_last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx + ID_WIDTH'(1);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign w_free = !r_res_valid || res_ready;
  assign w_xfer = w_found && w_free && ap_rst_n;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_xfer && (w_grant == ID_WIDTH'(i));
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_WIDTH'(i)) begin
        w_a = req_a[i*A_WIDTH +: A_WIDTH];
        w_b = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Zero-extend a to make it a non-negative signed value before the multiply.
  assign w_a_ext = P_WIDTH'($signed({1'b0, w_a}));
  assign w_b_ext = P_WIDTH'(w_b);
  assign w_p     = w_a_ext * w_b_ext;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_res_valid    <= 1'b0;
      r_res_p        <= '0;
      r_res_id       <= '0;
      r_last_grant   <= ID_WIDTH'(NUM_REQ - 1);
      r_issued_count <= '0;
    end else if (w_xfer) begin
      r_res_valid    <= 1'b1;
      r_res_p        <= w_p;
      r_res_id       <= w_grant;
      r_last_grant   <= w_grant;
      r_issued_count <= r_issued_count + 32'd1;
    end else if (r_res_valid && res_ready) begin
      r_res_valid    <= 1'b0;
    end
  end

  assign res_valid    = r_res_valid;
  assign res_p        = r_res_p;
  assign res_id       = r_res_id;
  assign issued_count = r_issued_count;

endmodule

// File: tb/tb_detect_faces_mul_arbiter.sv
// Self-checking bench for detect_faces_mul_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_detect_faces_mul_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 11;
  localparam int PW = 27;
  localparam int IW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic              res_valid;
  logic              res_ready;
  logic [PW-1:0]     res_p;
  logic [IW-1:0]     res_id;
  logic [31:0]       issued_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_valid;
  int          m_p;
  int          m_id;
  int          m_last;
  logic [31:0] m_count;
  int          m_gnt;

  always #5 ap_clk = ~ap_clk;

  detect_faces_mul_arbiter #(
    .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_p(res_p), .res_id(res_id), .issued_count(issued_count)
  );

  task automatic model_reset();
    m_valid = 0; m_p = 0; m_id = 0; m_last = N - 1; m_count = '0; m_gnt = -1;
  endtask

  // Winner index per round-robin rule, or -1 when nothing may be accepted.
  function automatic int model_winner();
    if (!ap_rst_n) return -1;
    if (m_valid && !res_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int w;
    logic [N-1:0] r;
    w = model_winner();
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic int model_prod(int i);
    int a;
    int b;
    a = int'(req_a[i*AW +: AW]);
    b = $signed(req_b[i*BW +: BW]);
    return a * b;
  endfunction

  // Advance the model across one rising edge and let the clock tick.
  task automatic tick();
    m_gnt = model_winner();
    if (m_gnt >= 0) begin
      m_p = model_prod(m_gnt); m_id = m_gnt; m_valid = 1; m_last = m_gnt;
      m_count = m_count + 32'd1;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(int i, int a, int b);
    req_a[i*AW +: AW] = a[AW-1:0];
    req_b[i*BW +: BW] = b[BW-1:0];
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    set_req(2, 1000, -3);
    req_valid = 4'b0100;
    model_reset();
    @(posedge ap_clk); #1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid actual=%b required=0", res_valid); end
    n_checks++; if (res_p !== '0) begin n_fail++; $display("FAIL reset_p actual=%0d required=0", $signed(res_p)); end
    n_checks++; if (issued_count !== 32'd0) begin n_fail++; $display("FAIL reset_count actual=%0d required=0", issued_count); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready actual=%b required=0000", req_ready); end
    ap_rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL first_ready actual=%b required=0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin n_fail++; $display("FAIL first_result valid=%b id=%0d required valid=1 id=2", res_valid, res_id); end
    n_checks++; if ($signed(res_p) !== -3000) begin n_fail++; $display("FAIL first_p actual=%0d required=-3000", $signed(res_p)); end
  endtask

  task automatic test_extremes();
    int ea[3] = '{65535, 65535, 0};
    int eb[3] = '{-1024, 1023, -1};
    int ep[3] = '{-67107840, 67042305, 0};
    for (int i = 0; i < 3; i++) begin
      logic [PW-1:0] e;
      e = ep[i][PW-1:0];
      set_req(1, ea[i], eb[i]);
      req_valid = 4'b0010; res_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL ext_ready%0d actual=%b required=0010", i, req_ready); end
      tick();
      req_valid = '0;
      n_checks++; if (res_p !== e || res_id !== 2'd1) begin n_fail++; $display("FAIL ext_p%0d actual=%0d id=%0d required=%0d id=1", i, $signed(res_p), res_id, ep[i]); end
    end
  endtask

  task automatic test_back_to_back();
    ap_rst_n = 1'b0; #1; model_reset(); ap_rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 2047)));
    req_valid = '1; res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic [PW-1:0] e;
      #1;
      tick();
      e = m_p[PW-1:0];
      n_checks++; if (res_valid !== 1'b1 || res_id !== IW'(c % N)) begin n_fail++; $display("FAIL b2b_id%0d valid=%b id=%0d required valid=1 id=%0d", c, res_valid, res_id, c % N); end
      n_checks++; if (res_p !== e) begin n_fail++; $display("FAIL b2b_p%0d actual=%0d required=%0d", c, $signed(res_p), m_p); end
      set_req(m_gnt, int'($urandom_range(0, 65535)), int'($urandom_range(0, 2047)));
    end
    n_checks++; if (issued_count !== 32'd8) begin n_fail++; $display("FAIL b2b_count actual=%0d required=8", issued_count); end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] sp;
    logic [IW-1:0] sid;
    sp = res_p; sid = res_id;
    req_valid = 4'b1010; res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d actual=%b required=0000", c, req_ready); end
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_p !== sp || res_id !== sid) begin n_fail++; $display("FAIL bp_hold%0d valid=%b p=%0d id=%0d required valid=1 p=%0d id=%0d", c, res_valid, $signed(res_p), res_id, $signed(sp), sid); end
    end
    res_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready actual=%b required=0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || issued_count !== m_count) begin n_fail++; $display("FAIL bp_nobubble valid=%b id=%0d count=%0d required valid=1 id=1 count=%0d", res_valid, res_id, issued_count, m_count); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1001; res_ready = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    n_checks++; if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_async valid=%b ready=%b required valid=0 ready=0000", res_valid, req_ready); end
    model_reset();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1; res_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_ready actual=%b required=0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    n_checks++; if (res_id !== 2'd0 || issued_count !== 32'd1) begin n_fail++; $display("FAIL midrst_first id=%0d count=%0d required id=0 count=1", res_id, issued_count); end
  endtask

  task automatic test_wrap();
    req_valid = '0;
    tick();
    force dut.r_issued_count = 32'hFFFF_FFFF;
    @(posedge ap_clk); #1;
    release dut.r_issued_count;
    m_count = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (issued_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload actual=%h required=ffffffff", issued_count); end
    set_req(3, 7, -5);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    n_checks++; if (issued_count !== 32'd0 || res_id !== 2'd3) begin n_fail++; $display("FAIL wrap_count actual=%0d id=%0d required count=0 id=3", issued_count, res_id); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0]  er;
      logic [PW-1:0] e;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 2047)));
          req_valid[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = model_ready();
      n_checks++; if (req_ready !== er) begin n_fail++; $display("FAIL rand_ready%0d actual=%b required=%b", c, req_ready, er); end
      tick();
      if (m_gnt >= 0) req_valid[m_gnt] = 1'b0;
      e = m_p[PW-1:0];
      n_checks++;
      if (res_valid !== m_valid || res_p !== e || res_id !== IW'(m_id) || issued_count !== m_count) begin
        n_fail++;
        $display("FAIL rand_result%0d valid=%b p=%0d id=%0d count=%0d required valid=%b p=%0d id=%0d count=%0d",
                 c, res_valid, $signed(res_p), res_id, issued_count, m_valid, m_p, m_id, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
